// File: rtl/switches_ctrl.sv
// Switch debounce / change-detect controller with a small word-addressed register port.
// All switch bits are debounced together as one vector; a commit latches a pending flag that drives irq_o.
module switches_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SW_W            = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [SW_W-1:0] sw_i,
  input  logic            re_i,
  input  logic            we_i,
  input  logic [1:0]      addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic            rvalid_o,
  output logic            irq_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STABLE   = 2'd0,
    ST_SETTLING = 2'd1,
    ST_COMMIT   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [SW_W-1:0]   meta_reg, sync_reg;
  logic [SW_W-1:0]   cand_reg, cand_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [SW_W-1:0]   stable_reg, prev_reg;
  logic              pending_reg, irq_en_reg;
  logic              commit;
  logic              status_wr;
  logic [31:0]       read_mux;
  logic              wdata_unused;

  assign wdata_unused = ^wdata_i[31:2];

  // Two-flop synchroniser; sw_i is asynchronous to clk_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= sw_i;
      sync_reg <= meta_reg;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_STABLE;
      cand_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_STABLE: begin
        if (sync_reg != stable_reg) begin
          state_next = ST_SETTLING;
          cand_next  = sync_reg;
          cnt_next   = '0;
        end
      end
      ST_SETTLING: begin
        if (sync_reg == stable_reg) begin
          state_next = ST_STABLE;
        end else if (sync_reg != cand_reg) begin
          cand_next = sync_reg;
          cnt_next  = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_next == CNT_LAST) state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: state_next = ST_STABLE;
      default:   state_next = ST_STABLE;
    endcase
  end

  always_comb begin
    commit = (state_reg == ST_COMMIT);
  end

  assign status_wr = we_i && (addr_i == 2'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_reg  <= '0;
      prev_reg    <= '0;
      pending_reg <= 1'b0;
      irq_en_reg  <= 1'b0;
    end else begin
      if (commit) begin
        prev_reg   <= stable_reg;
        stable_reg <= cand_reg;
      end
      // A commit in the same cycle as a W1C clear keeps the flag set.
      if (commit)
        pending_reg <= 1'b1;
      else if (status_wr && wdata_i[0])
        pending_reg <= 1'b0;
      if (status_wr)
        irq_en_reg <= wdata_i[1];
    end
  end

  always_comb begin
    read_mux = '0;
    case (addr_i)
      2'd0:    read_mux[SW_W-1:0] = stable_reg;
      2'd1:    read_mux[1:0]      = {irq_en_reg, pending_reg};
      2'd2:    read_mux[SW_W-1:0] = prev_reg;
      default: read_mux = '0;
    endcase
  end

  // Reads sample pre-write register values, so a same-cycle write is not visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= re_i;
      if (re_i) rdata_o <= read_mux;
    end
  end

  assign irq_o = pending_reg & irq_en_reg;

endmodule

// File: tb/tb_switches_ctrl.sv
// Bench for switches_ctrl: directed scenarios plus randomized traffic, compared each cycle
// against a window-based reference model of the debounce rule.
module tb_switches_ctrl;

  localparam int DC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic        re, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata_o;
  logic        rvalid_o, irq_o;

  int total = 0;
  int bad   = 0;

  switches_ctrl #(.DEBOUNCE_CYCLES(DC), .SW_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .sw_i(sw), .re_i(re), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Reference model: the synchronised value seen at each edge is the input two edges
  // earlier; a commit happens at edge t when the DC samples before t all hold one value
  // different from the committed one, and none of them is at or before the last commit.
  logic [15:0] m_d1, m_d2, m_stable, m_prev, v;
  logic [15:0] hist[$];
  logic        m_pending, m_irq_en, m_rvalid, m_commit, all_eq;
  logic [31:0] m_rdata;
  int          edge_n, last_commit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; hist.delete();
      edge_n = 0; last_commit = -1000;
      m_stable = '0; m_prev = '0; m_pending = 0; m_irq_en = 0;
      m_rdata = '0; m_rvalid = 0;
    end else begin
      edge_n++;
      m_commit = 0;
      if (hist.size() >= DC && (edge_n - DC) > last_commit) begin
        v = hist[hist.size()-1];
        all_eq = 1;
        for (int i = 0; i < DC; i++)
          if (hist[hist.size()-1-i] != v) all_eq = 0;
        if (all_eq && v != m_stable) m_commit = 1;
      end
      m_rvalid = re;
      if (re) begin
        case (addr)
          2'd0: m_rdata = {16'b0, m_stable};
          2'd1: m_rdata = {30'b0, m_irq_en, m_pending};
          2'd2: m_rdata = {16'b0, m_prev};
          default: m_rdata = '0;
        endcase
      end
      if (m_commit) begin
        m_prev = m_stable; m_stable = v; m_pending = 1; last_commit = edge_n;
      end else if (we && addr == 2'd1 && wdata[0]) begin
        m_pending = 0;
      end
      if (we && addr == 2'd1) m_irq_en = wdata[1];
      hist.push_back(m_d2);
      if (hist.size() > DC) void'(hist.pop_front());
      m_d2 = m_d1;
      m_d1 = sw;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("model_rdata", rdata_o, m_rdata);
    check("model_rvalid", 32'(rvalid_o), 32'(m_rvalid));
    check("model_irq", 32'(irq_o), 32'(m_pending & m_irq_en));
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
    re = 1; addr = a;
    tick();
    check("rd_data", rdata_o, exp);
    check("rd_valid", 32'(rvalid_o), 32'd1);
    re = 0;
    tick();
    check("rd_pulse", 32'(rvalid_o), 32'd0);
    check("rd_hold", rdata_o, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d;
    tick();
    we = 0;
  endtask

  initial begin
    int hold;
    rst = 1; sw = '0; re = 0; we = 0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 0;

    // Reset state
    check("rst_irq", 32'(irq_o), 32'd0);
    bus_read(2'd0, 32'h0);
    bus_read(2'd1, 32'h0);
    bus_read(2'd2, 32'h0);

    // Glitch shorter than the debounce window is dropped
    sw = 16'h0001;
    repeat (5) tick();
    sw = 16'h0000;
    repeat (15) tick();
    bus_read(2'd0, 32'h0);
    bus_read(2'd1, 32'h0);

    // Clean edge: stable updates at edge 11, visible to a read at edge 12
    sw = 16'h00A5; re = 1; addr = 2'd0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("latency", rdata_o, (i < 12) ? 32'h0 : 32'hA5);
    end
    re = 0;
    bus_read(2'd1, 32'h1);
    bus_read(2'd2, 32'h0);

    // Bounce on bit3, then hold: one commit 11 cycles after the last toggle
    bus_write(2'd1, 32'h1);
    for (int t = 0; t < 4; t++) begin
      sw = (t % 2 == 0) ? 16'h00AD : 16'h00A5;
      repeat (3) tick();
    end
    sw = 16'h00AD; re = 1; addr = 2'd0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("bounce", rdata_o, (i < 12) ? 32'hA5 : 32'hAD);
    end
    re = 0;
    bus_read(2'd2, 32'hA5);
    bus_read(2'd1, 32'h1);

    // IRQ enable, commit raises irq_o, W1C drops it
    bus_write(2'd1, 32'h1);
    bus_write(2'd1, 32'h2);
    check("irq_idle", 32'(irq_o), 32'd0);
    sw = 16'h00F0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("irq_rise", 32'(irq_o), (i == 11) ? 32'd1 : 32'd0);
    end
    bus_write(2'd1, 32'h3);
    check("irq_clear", 32'(irq_o), 32'd0);

    // Read timing, unused address, simultaneous read and write
    bus_read(2'd3, 32'h0);
    bus_read(2'd1, 32'h2);
    re = 1; we = 1; addr = 2'd1; wdata = 32'h0;
    tick();
    check("rw_prewrite", rdata_o, 32'h2);
    re = 0; we = 0;
    tick();
    bus_read(2'd1, 32'h0);
    bus_write(2'd1, 32'h2);

    // W1C in the COMMIT cycle loses to the set
    sw = 16'h000F;
    repeat (10) tick();
    we = 1; addr = 2'd1; wdata = 32'h3;
    tick();
    we = 0;
    check("set_wins", 32'(irq_o), 32'd1);
    bus_read(2'd1, 32'h3);

    // Asynchronous reset mid-cycle clears outputs immediately
    re = 1; addr = 2'd0;
    @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(rvalid_o), 32'd1);
    check("pre_rst_data", rdata_o, 32'h0F);
    check("pre_rst_irq", 32'(irq_o), 32'd1);
    rst = 1;
    #1;
    check("async_rdata", rdata_o, 32'h0);
    check("async_rvalid", 32'(rvalid_o), 32'd0);
    check("async_irq", 32'(irq_o), 32'd0);
    re = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    bus_read(2'd0, 32'h0);
    bus_read(2'd1, 32'h0);
    bus_read(2'd2, 32'h0);

    // Randomized traffic against the model
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      if (hold == 0) begin
        sw = 16'($urandom_range(0, 7)) << 2;
        hold = $urandom_range(1, 14);
      end
      re = 1'($urandom_range(0, 1));
      addr = 2'($urandom_range(0, 3));
      we = ($urandom_range(0, 5) == 0);
      wdata = 32'($urandom_range(0, 3));
      tick();
      hold--;
    end
    re = 0; we = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
